// File: rtl/buffer_uart_tx_if.sv
// Pop-style handshake between an upstream word buffer and the UART transmitter.
// The buffer presents its head word and valid flag; the transmitter pulses buf_read to pop it.
interface buffer_uart_tx_if #(
    parameter int DATA_WIDTH = 9
);
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  buf_valid;
    logic                  buf_read;

    modport master (
        output buf_data,
        output buf_valid,
        input  buf_read
    );

    modport slave (
        input  buf_data,
        input  buf_valid,
        output buf_read
    );
endinterface

// File: rtl/buffer_uart_tx.sv
// Pops 9-bit words from a buffer and sends each one as two UART frames (sync-marked A, then B).
// Define UART_PARITY_EN to add an even-parity bit to every frame (8E1); default is 8N1.
module buffer_uart_tx #(
    parameter int DATA_WIDTH   = 9,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic            clk,
    input  logic            rst,
    buffer_uart_tx_if.slave bus,
    output logic            tx,
    output logic            busy
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [2:0]            bit_reg, bit_next;
    logic                  frame_b_reg, frame_b_next;
    logic [DATA_WIDTH-1:0] hold_reg, hold_next;
    logic                  tx_reg, tx_next;
    logic                  buf_read_reg, buf_read_next;
    logic                  busy_reg, busy_next;
    logic                  bit_done;
    logic [7:0]            frame_byte_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            frame_b_reg  <= 1'b0;
            hold_reg     <= '0;
            tx_reg       <= 1'b1;
            buf_read_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_reg      <= bit_next;
            frame_b_reg  <= frame_b_next;
            hold_reg     <= hold_next;
            tx_reg       <= tx_next;
            buf_read_reg <= buf_read_next;
            busy_reg     <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_next     = bit_reg;
        frame_b_next = frame_b_reg;
        hold_next    = hold_reg;
        bit_done     = (cnt_reg == CNT_MAX);
        cnt_next     = (state_reg == IDLE || bit_done) ? '0 : cnt_reg + CNT_W'(1);
        case (state_reg)
            IDLE: begin
                bit_next = '0;
                if (bus.buf_valid) begin
                    hold_next    = bus.buf_data;
                    frame_b_next = 1'b0;
                    state_next   = START;
                end
            end
            START: begin
                if (bit_done) begin
                    bit_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_reg == 3'd7) begin
                        bit_next = '0;
`ifdef UART_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) state_next = STOP;
            end
            STOP: begin
                // Frame A chains straight into frame B; after B the line idles for at least a cycle.
                if (bit_done) begin
                    if (!frame_b_reg) begin
                        frame_b_next = 1'b1;
                        state_next   = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so they register in step with it.
    always_comb begin
        frame_byte_next = frame_b_next ? {1'b0, hold_next[6:0]}
                                       : {1'b1, 5'b00000, hold_next[8:7]};
        buf_read_next   = (state_reg == IDLE) && bus.buf_valid;
        busy_next       = (state_next != IDLE);
        case (state_next)
            IDLE:    tx_next = 1'b1;
            START:   tx_next = 1'b0;
            DATA:    tx_next = frame_byte_next[bit_next];
            PARITY:  tx_next = ^frame_byte_next;
            STOP:    tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase
    end

    assign tx           = tx_reg;
    assign busy         = busy_reg;
    assign bus.buf_read = buf_read_reg;
endmodule

// File: tb/tb_buffer_uart_tx.sv
// Directed bench for buffer_uart_tx at CLKS_PER_BIT=4; follows UART_PARITY_EN like the design.
`timescale 1ns/1ps
module tb_buffer_uart_tx;
    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int FRAME_BITS = 10;
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = FRAME_BITS * CPB;
    localparam int WL = 2 * FL;

    logic clk = 1'b0;
    logic rst;
    logic tx;
    logic busy;
    int   n_checks = 0;
    int   n_pass = 0;
    logic tx_log   [0:1023];
    logic busy_log [0:1023];
    logic rd_log   [0:1023];

    buffer_uart_tx_if #(.DATA_WIDTH(9)) bus ();

    buffer_uart_tx #(.DATA_WIDTH(9), .CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic log_sample(input int i);
        tx_log[i]   = tx;
        busy_log[i] = busy;
        rd_log[i]   = bus.buf_read;
    endtask

    function automatic logic [7:0] frame_of(input logic [8:0] w, input bit second);
        return second ? {1'b0, w[6:0]} : {1'b1, 5'b00000, w[8:7]};
    endfunction

    function automatic logic exp_tx(input logic [8:0] w, input int i);
        logic [7:0] fb;
        int b;
        if (i >= WL) return 1'b1;
        fb = frame_of(w, (i / FL) == 1);
        b  = (i % FL) / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return fb[b-1];
        if (PAR && b == 9) return ^fb;
        return 1'b1;
    endfunction

    function automatic logic [7:0] decode_byte(input int base, input int f);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = tx_log[base + f*FL + (b+1)*CPB + CPB/2];
        return v;
    endfunction

    function automatic logic parity_bit(input int base, input int f);
        return tx_log[base + f*FL + 9*CPB + CPB/2];
    endfunction

    function automatic int wave_errors(input logic [8:0] w, input int base);
        int e = 0;
        for (int i = 0; i <= WL; i++) if (tx_log[base+i] !== exp_tx(w, i)) e++;
        return e;
    endfunction

    // Present one word for a single edge, optionally clobber buf_data afterwards, and log n samples.
    task automatic capture_word(input logic [8:0] w, input bit clobber, input int n);
        bus.buf_data  = w;
        bus.buf_valid = 1'b1;
        tick();
        log_sample(0);
        bus.buf_valid = 1'b0;
        if (clobber) bus.buf_data = 9'h000;
        for (int i = 1; i < n; i++) begin
            tick();
            log_sample(i);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.buf_valid = 1'b0;
        bus.buf_data  = 9'h000;
        repeat (3) tick();
        if (tx !== 1'b1) $display("FAIL reset_tx got %b want 1", tx); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++;
        if (bus.buf_read !== 1'b0) $display("FAIL reset_read got %b want 0", bus.buf_read); else n_pass++;
        n_checks++;
        rst = 1'b0;
        tick();
        $display("reset: tx=%b busy=%b read=%b", tx, busy, bus.buf_read);
    endtask

    task automatic test_idle();
        int tx_low = 0, reads = 0, busies = 0;
        bus.buf_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx !== 1'b1) tx_low++;
            if (bus.buf_read !== 1'b0) reads++;
            if (busy !== 1'b0) busies++;
        end
        if (tx_low != 0) $display("FAIL idle_tx got %0d low cycles want 0", tx_low); else n_pass++;
        n_checks++;
        if (reads != 0) $display("FAIL idle_read got %0d pulses want 0", reads); else n_pass++;
        n_checks++;
        if (busies != 0) $display("FAIL idle_busy got %0d busy cycles want 0", busies); else n_pass++;
        n_checks++;
        $display("idle 100 cycles: tx_low=%0d reads=%0d busy=%0d", tx_low, reads, busies);
    endtask

    task automatic test_single_word();
        logic [7:0] a, b;
        int reads = 0, mm;
        capture_word(9'h1A5, 1'b0, WL + 4);
        if (rd_log[0] !== 1'b1 || tx_log[0] !== 1'b0 || busy_log[0] !== 1'b1)
            $display("FAIL single_accept got read=%b tx=%b busy=%b want 1 0 1", rd_log[0], tx_log[0], busy_log[0]);
        else n_pass++;
        n_checks++;
        for (int i = 0; i < WL + 4; i++) if (rd_log[i] === 1'b1) reads++;
        if (reads != 1) $display("FAIL single_reads got %0d want 1", reads); else n_pass++;
        n_checks++;
        a = decode_byte(0, 0);
        b = decode_byte(0, 1);
        if (a !== 8'h83) $display("FAIL single_frame_a got %h want 83", a); else n_pass++;
        n_checks++;
        if (b !== 8'h25) $display("FAIL single_frame_b got %h want 25", b); else n_pass++;
        n_checks++;
`ifdef UART_PARITY_EN
        if (parity_bit(0, 0) !== 1'b1 || parity_bit(0, 1) !== 1'b1)
            $display("FAIL single_parity got %b%b want 11", parity_bit(0, 0), parity_bit(0, 1));
        else n_pass++;
        n_checks++;
`endif
        mm = wave_errors(9'h1A5, 0);
        if (mm != 0) $display("FAIL single_waveform got %0d bad cycles want 0", mm); else n_pass++;
        n_checks++;
        if (busy_log[WL-1] !== 1'b1 || busy_log[WL] !== 1'b0)
            $display("FAIL single_busy_end got %b%b want 10", busy_log[WL-1], busy_log[WL]);
        else n_pass++;
        n_checks++;
        $display("word 1a5: frame_a=%h frame_b=%h reads=%0d", a, b, reads);
    endtask

    task automatic test_back_to_back();
        logic [8:0] words [3] = '{9'h0C3, 9'h17E, 9'h055};
        logic [7:0] exp_a [3] = '{8'h81, 8'h82, 8'h80};
        logic [7:0] exp_b [3] = '{8'h43, 8'h7E, 8'h55};
        int rpos [3] = '{0, 0, 0};
        int nr = 0;
        int n = 3 * (WL + 1) + 8;
        logic [7:0] a, b;
        int mm;
        bus.buf_data  = words[0];
        bus.buf_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            log_sample(i);
            if (bus.buf_read === 1'b1) begin
                if (nr < 3) rpos[nr] = i;
                nr++;
                if (nr < 3) bus.buf_data = words[nr];
                else begin
                    bus.buf_valid = 1'b0;
                    bus.buf_data  = 9'h000;
                end
            end
        end
        bus.buf_valid = 1'b0;
        if (nr != 3) $display("FAIL b2b_reads got %0d want 3", nr); else n_pass++;
        n_checks++;
        for (int j = 0; j < 3 && j < nr; j++) begin
            if (j > 0) begin
                if (rpos[j] - rpos[j-1] != WL + 1)
                    $display("FAIL b2b_gap%0d got %0d want %0d", j, rpos[j] - rpos[j-1], WL + 1);
                else n_pass++;
                n_checks++;
            end
            a = decode_byte(rpos[j], 0);
            b = decode_byte(rpos[j], 1);
            if (a !== exp_a[j] || b !== exp_b[j])
                $display("FAIL b2b_word%0d got %h %h want %h %h", j, a, b, exp_a[j], exp_b[j]);
            else n_pass++;
            n_checks++;
            mm = wave_errors(words[j], rpos[j]);
            if (mm != 0) $display("FAIL b2b_wave%0d got %0d bad cycles want 0", j, mm); else n_pass++;
            n_checks++;
            $display("b2b word %0d (%h) at cycle %0d: frame_a=%h frame_b=%h", j, words[j], rpos[j], a, b);
        end
    endtask

    task automatic test_data_change();
        logic [7:0] a, b;
        int mm;
        capture_word(9'h1FF, 1'b1, WL + 4);
        a = decode_byte(0, 0);
        b = decode_byte(0, 1);
        if (a !== 8'h83) $display("FAIL hold_frame_a got %h want 83", a); else n_pass++;
        n_checks++;
        if (b !== 8'h7F) $display("FAIL hold_frame_b got %h want 7f", b); else n_pass++;
        n_checks++;
        mm = wave_errors(9'h1FF, 0);
        if (mm != 0) $display("FAIL hold_waveform got %0d bad cycles want 0", mm); else n_pass++;
        n_checks++;
        $display("word 1ff with data clobbered: frame_a=%h frame_b=%h", a, b);
    endtask

    task automatic test_reset_mid();
        int lows = 0, reads = 0;
        logic [7:0] a, b;
        bus.buf_data  = 9'h1A5;
        bus.buf_valid = 1'b1;
        tick();
        bus.buf_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        if (tx !== 1'b1 || busy !== 1'b0 || bus.buf_read !== 1'b0)
            $display("FAIL midreset_abort got tx=%b busy=%b read=%b want 1 0 0", tx, busy, bus.buf_read);
        else n_pass++;
        n_checks++;
        rst = 1'b0;
        for (int i = 0; i < WL + 4; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
            if (bus.buf_read !== 1'b0) reads++;
        end
        if (lows != 0 || reads != 0)
            $display("FAIL midreset_quiet got %0d low cycles %0d reads want 0 0", lows, reads);
        else n_pass++;
        n_checks++;
        capture_word(9'h055, 1'b0, WL + 4);
        a = decode_byte(0, 0);
        b = decode_byte(0, 1);
        if (rd_log[0] !== 1'b1 || a !== 8'h80 || b !== 8'h55)
            $display("FAIL midreset_next got read=%b %h %h want 1 80 55", rd_log[0], a, b);
        else n_pass++;
        n_checks++;
        $display("reset in frame A data: quiet lows=%0d, next word frame_a=%h frame_b=%h", lows, a, b);
    endtask

    task automatic test_reset_priority();
        bus.buf_data  = 9'h1A5;
        bus.buf_valid = 1'b1;
        rst = 1'b1;
        tick();
        if (bus.buf_read !== 1'b0 || tx !== 1'b1 || busy !== 1'b0)
            $display("FAIL rst_priority got read=%b tx=%b busy=%b want 0 1 0", bus.buf_read, tx, busy);
        else n_pass++;
        n_checks++;
        rst = 1'b0;
        bus.buf_valid = 1'b0;
        tick();
        $display("rst and valid together: read=%b tx=%b", bus.buf_read, tx);
    endtask

    initial begin
        rst = 1'b1;
        bus.buf_valid = 1'b0;
        bus.buf_data  = 9'h000;
        test_reset();
        test_idle();
        test_single_word();
        test_back_to_back();
        test_data_change();
        test_reset_mid();
        test_reset_priority();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/buffer_uart_tx.md
BUFFER_UART_TX -- requirements
Module: buffer_uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 9, width of the word popped from the upstream buffer (fixed at 9; other values unsupported).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2.
REQ-003 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset; clock clk.
REQ-005 SHALL have port buf_data  input  DATA_WIDTH  head word presented by the upstream buffer.
REQ-006 SHALL have port buf_valid  input  1  upstream buffer holds at least one word; buf_data is valid.
REQ-007 SHALL have port buf_read  output  1  one-cycle pop strobe to the upstream buffer.
REQ-008 SHALL have port tx  output  1  UART serial line, idle high.
REQ-009 SHALL have port busy  output  1  word transmission in progress.

Function
REQ-010 SHALL encode each word as two 8-bit frames: frame A = {1'b1, 5'b00000, buf_data[8:7]}, then frame B = {1'b0, buf_data[6:0]}; MSB is the host sync marker.
REQ-011 SHALL send each frame as start bit (0), 8 data bits LSB first, optional parity (REQ-021), stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP; a frame-select flag chooses A or B.
REQ-013 In IDLE, at the first edge with buf_valid=1: capture buf_data into a holding register, drive buf_read=1, tx=0, busy=1, select frame A, enter START.
REQ-014 SHALL hold buf_read high for exactly one cycle per word and never assert it outside the IDLE->START transition.
REQ-015 SHALL transition START->DATA, DATA->PARITY (or STOP if parity disabled) after 8 bits, PARITY->STOP, each after CLKS_PER_BIT cycles.
REQ-016 At end of STOP for frame A SHALL enter START for frame B with no idle gap.
REQ-017 At end of STOP for frame B SHALL enter IDLE with tx=1, busy=0; IDLE SHALL spend at least one cycle before accepting the next word.
REQ-018 SHALL ignore buf_valid and buf_data changes while busy=1; transmitted bits come only from the holding register.
REQ-019 Bit-cycle counter SHALL be ceil(log2(CLKS_PER_BIT)) bits, count 0..CLKS_PER_BIT-1, wrap to 0 at each bit boundary; bit index counter 0..7.
REQ-020 tx SHALL be a registered output, glitch-free.

Configuration
REQ-021 With macro UART_PARITY_EN defined, SHALL insert an even-parity bit (XOR of the 8 frame bits) between data and stop bits, 11 bits per frame; without it, SHALL skip PARITY (8N1, 10 bits per frame).

Reset
REQ-022 On rst=1 at an edge: state IDLE, tx=1, buf_read=0, busy=0, counters and holding register 0.
REQ-023 Reset mid-word SHALL abort transmission (tx high from next edge), not issue buf_read, and not retransmit the aborted word; a word already popped is lost.
REQ-024 rst SHALL take priority over buf_valid in the same cycle.

Verification (CLKS_PER_BIT=4)
REQ-025 buf_valid=1, buf_data=9'h1A5 -> one buf_read pulse; tx sends 0x83 then 0x25, frame length 40 cycles each (44 with UART_PARITY_EN, parity bits 1 and 1); busy low after 80 (88) cycles.
REQ-026 buf_valid held high with 3 words queued -> exactly 3 buf_read pulses, each separated by 81 cycles (89 with parity), frames in order.
REQ-027 buf_data changes to 9'h000 during transmission of 9'h1FF -> tx still sends 0x83, 0x7F.
REQ-028 rst asserted in DATA of frame A -> tx=1 and busy=0 next cycle; no frame B; next word starts normally after rst release.
REQ-029 buf_valid=0 for 100 cycles -> tx stays 1, buf_read stays 0, busy stays 0.
REQ-030 buf_valid and rst both high on same edge -> no buf_read, tx=1.
